// File: rtl/ibex_fetch_req_ctrl.sv
// ibex_fetch_req_ctrl: instruction-bus fetch request controller feeding the fetch FIFO.
// Issues word-aligned requests, tracks up to NUM_REQS outstanding transactions and
// forwards responses to the FIFO. A branch clears the FIFO, redirects fetching and
// marks every response still in flight from before the branch for discard.
// Optional feature macro: IBEX_FETCH_ERR_STOP_EN (stop fetching after a forwarded bus error).
//
// Handshake: instr_req_o/instr_addr_o stay stable from the first cycle instr_req_o is
// high until the cycle instr_gnt_i is seen with it; a request+grant cycle is one
// transaction. Each instr_rvalid_i retires the oldest granted transaction in order.
module ibex_fetch_req_ctrl #(
    parameter int NUM_REQS = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    output logic        busy_o,
    output logic        fifo_clear_o,
    output logic        fifo_valid_o,
    input  logic        fifo_ready_i,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i
);

    localparam int CW = $clog2(NUM_REQS + 1);

    // Next address to request, and the held (ungranted) request
    logic [31:0]         fetch_addr_q;
    logic                pend_q;
    logic [31:0]         pend_addr_q;
    logic                pend_discard_q;

    // Outstanding transactions: count plus one discard bit per entry, entry 0 oldest
    logic [CW-1:0]       cnt_q, cnt_n;
    logic [NUM_REQS-1:0] disc_q, disc_n;

    logic                issue;
    logic                push;
    logic                pop;
    logic                new_disc;
    logic [31:0]         branch_word;

`ifdef IBEX_FETCH_ERR_STOP_EN
    logic                stop_q;
`endif

    assign branch_word = {addr_i[31:2], 2'b00};

    // Request issue and bus address selection
    always_comb begin
        issue = req_i & ~pend_q & (fifo_ready_i | branch_i) & (cnt_q < CW'(NUM_REQS));
`ifdef IBEX_FETCH_ERR_STOP_EN
        // A branch overrides the error stop and restarts fetching immediately
        issue = issue & (~stop_q | branch_i);
`endif
        instr_req_o  = pend_q | issue;
        if (pend_q) begin
            instr_addr_o = pend_addr_q;
        end else if (branch_i) begin
            instr_addr_o = branch_word;
        end else begin
            instr_addr_o = fetch_addr_q;
        end
    end

    assign push     = instr_req_o & instr_gnt_i;
    assign pop      = instr_rvalid_i & (cnt_q != '0);
    // Only a held request can predate the branch; a request issued in the branch cycle is the target
    assign new_disc = pend_q & (pend_discard_q | branch_i);

    // Outstanding queue update: pop oldest, mark survivors on branch, then push the new entry
    always_comb begin
        disc_n = disc_q;
        cnt_n  = cnt_q;
        if (pop) begin
            disc_n = disc_q >> 1;
            cnt_n  = cnt_q - CW'(1);
        end
        if (branch_i) begin
            disc_n = '1;
        end
        if (push) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (CW'(i) == cnt_n) begin
                    disc_n[i] = new_disc;
                end
            end
            cnt_n = cnt_n + CW'(1);
        end
    end

    // Response forwarding and branch-side FIFO control
    always_comb begin
        fifo_valid_o = pop & ~disc_q[0] & ~branch_i;
        fifo_rdata_o = instr_rdata_i;
        fifo_err_o   = instr_err_i;
        fifo_clear_o = branch_i;
        fifo_addr_o  = addr_i;
        busy_o       = pend_q | (cnt_q != '0);
    end

    // State registers: outstanding queue, held request and fetch address
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q          <= '0;
            disc_q         <= '0;
            pend_q         <= 1'b0;
            pend_addr_q    <= '0;
            pend_discard_q <= 1'b0;
            fetch_addr_q   <= '0;
        end else begin
            cnt_q  <= cnt_n;
            disc_q <= disc_n;
            if (pend_q) begin
                pend_q <= ~instr_gnt_i;
                if (branch_i) begin
                    pend_discard_q <= 1'b1;
                end
            end else if (issue && !instr_gnt_i) begin
                pend_q         <= 1'b1;
                pend_addr_q    <= instr_addr_o;
                pend_discard_q <= 1'b0;
            end
            // A new request advances the fetch pointer; a branch without a new request
            // loads the target so it is requested once the held request is granted
            if (issue) begin
                fetch_addr_q <= instr_addr_o + 32'd4;
            end else if (branch_i) begin
                fetch_addr_q <= branch_word;
            end
        end
    end

`ifdef IBEX_FETCH_ERR_STOP_EN
    // Error stop flag: set by a forwarded erroneous response, cleared by a branch
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stop_q <= 1'b0;
        end else if (branch_i) begin
            stop_q <= 1'b0;
        end else if (fifo_valid_o && instr_err_i) begin
            stop_q <= 1'b1;
        end
    end
`endif

    // Protocol check: a response must always have an outstanding transaction to retire
    always_ff @(posedge clk_i) begin
        if (rst_ni && instr_rvalid_i) begin
            assert (cnt_q != '0);
        end
    end

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed, table-driven bench for ibex_fetch_req_ctrl (NUM_REQS = 2).
module tb_ibex_fetch_req_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        branch;
    logic [31:0] addr;
    logic        busy;
    logic        fifo_clear;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [31:0] fifo_addr;
    logic [31:0] fifo_rdata;
    logic        fifo_err;
    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        chk;
        logic        rst_n;
        logic        req;
        logic        branch;
        logic [31:0] addr;
        logic        ready;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        e_req;
        logic [31:0] e_iaddr;
        logic        e_valid;
        logic        e_clear;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .branch_i       (branch),
        .addr_i         (addr),
        .busy_o         (busy),
        .fifo_clear_o   (fifo_clear),
        .fifo_valid_o   (fifo_valid),
        .fifo_ready_i   (fifo_ready),
        .fifo_addr_o    (fifo_addr),
        .fifo_rdata_o   (fifo_rdata),
        .fifo_err_o     (fifo_err),
        .instr_req_o    (instr_req),
        .instr_gnt_i    (instr_gnt),
        .instr_addr_o   (instr_addr),
        .instr_rvalid_i (instr_rvalid),
        .instr_rdata_i  (instr_rdata),
        .instr_err_i    (instr_err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t v(input logic chk, input logic rst_n_i, input logic req_i,
                               input logic br, input logic [31:0] a, input logic rdy,
                               input logic g, input logic rv, input logic [31:0] rd,
                               input logic er, input logic e_req, input logic [31:0] e_ia,
                               input logic e_val, input logic e_clr, input logic e_bsy);
        vec_t t;
        t.chk = chk; t.rst_n = rst_n_i; t.req = req_i; t.branch = br; t.addr = a;
        t.ready = rdy; t.gnt = g; t.rvalid = rv; t.rdata = rd; t.err = er;
        t.e_req = e_req; t.e_iaddr = e_ia; t.e_valid = e_val; t.e_clear = e_clr;
        t.e_busy = e_bsy;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the clock edge, compare outputs mid-cycle
    task automatic apply(input vec_t t, input string tag);
        @(posedge clk);
        #1;
        rst_n        = t.rst_n;
        req          = t.req;
        branch       = t.branch;
        addr         = t.addr;
        fifo_ready   = t.ready;
        instr_gnt    = t.gnt;
        instr_rvalid = t.rvalid;
        instr_rdata  = t.rdata;
        instr_err    = t.err;
        #3;
        if (t.chk) begin
            check({tag, ".instr_req"}, {31'd0, instr_req}, {31'd0, t.e_req});
            if (t.e_req) check({tag, ".instr_addr"}, instr_addr, t.e_iaddr);
            check({tag, ".fifo_valid"}, {31'd0, fifo_valid}, {31'd0, t.e_valid});
            if (t.e_valid) begin
                check({tag, ".fifo_rdata"}, fifo_rdata, t.rdata);
                check({tag, ".fifo_err"}, {31'd0, fifo_err}, {31'd0, t.err});
            end
            check({tag, ".fifo_clear"}, {31'd0, fifo_clear}, {31'd0, t.e_clear});
            if (t.e_clear) check({tag, ".fifo_addr"}, fifo_addr, t.addr);
            check({tag, ".busy"}, {31'd0, busy}, {31'd0, t.e_busy});
        end
    endtask

    initial begin
        logic stop_en;
`ifdef IBEX_FETCH_ERR_STOP_EN
        stop_en = 1'b1;
`else
        stop_en = 1'b0;
`endif
        rst_n = 1'b0; req = 1'b0; branch = 1'b0; addr = '0; fifo_ready = 1'b0;
        instr_gnt = 1'b0; instr_rvalid = 1'b0; instr_rdata = '0; instr_err = 1'b0;

        //            chk rst req br addr          rdy gnt rv rdata         err  e_req e_iaddr      val clr busy
        // Reset
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,   0, 32'h0,        0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,   0, 32'h0,        0, 0, 0));
        // Branch to 0x1000, grant every cycle, stall at two outstanding
        vecs.push_back(v(1, 1, 1, 1, 32'h1000,     1, 1, 0, 32'h0,        0,   1, 32'h1000,     0, 1, 0));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0,   1, 32'h1004,     0, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0,   0, 32'h0,        0, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h0,        1, 0, 1, 32'hAAAA0001, 0,   0, 32'h0,        1, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 1, 32'hAAAA0002, 0,   1, 32'h1008,     1, 0, 1));
        // Branch to halfword-aligned 0x2006 issues 0x2004 in the same cycle
        vecs.push_back(v(1, 1, 1, 1, 32'h2006,     1, 1, 0, 32'h0,        0,   1, 32'h2004,     0, 1, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 1, 32'hBBBB0008, 0,   0, 32'h0,        0, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 1, 32'hCCCC2004, 0,   1, 32'h2008,     1, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h0,        1, 0, 1, 32'hCCCC2008, 0,   0, 32'h0,        1, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 0, 0));
        // Two outstanding, branch to 0x3000, both old responses dropped
        vecs.push_back(v(1, 1, 1, 1, 32'h1000,     1, 1, 0, 32'h0,        0,   1, 32'h1000,     0, 1, 0));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0,   1, 32'h1004,     0, 0, 1));
        vecs.push_back(v(1, 1, 1, 1, 32'h3000,     1, 1, 0, 32'h0,        0,   0, 32'h0,        0, 1, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 1, 32'hDEAD1000, 0,   0, 32'h0,        0, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 1, 32'hDEAD1004, 0,   1, 32'h3000,     0, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h0,        1, 0, 1, 32'h30003000, 0,   0, 32'h0,        1, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 0, 0));
        // Held request at 0x1008, branch to 0x4000 while held
        vecs.push_back(v(1, 1, 1, 1, 32'h1000,     1, 1, 0, 32'h0,        0,   1, 32'h1000,     0, 1, 0));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 1, 32'h11110000, 0,   1, 32'h1004,     1, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 0, 1, 32'h11110004, 0,   1, 32'h1008,     1, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 0, 0, 32'h0,        0,   1, 32'h1008,     0, 0, 1));
        vecs.push_back(v(1, 1, 1, 1, 32'h4000,     1, 0, 0, 32'h0,        0,   1, 32'h1008,     0, 1, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0,   1, 32'h1008,     0, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0,   1, 32'h4000,     0, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h0,        1, 0, 1, 32'h99991008, 0,   0, 32'h0,        0, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h0,        1, 0, 1, 32'h44444000, 0,   0, 32'h0,        1, 0, 1));
        // FIFO not ready: only the branch target goes out, resume when ready
        vecs.push_back(v(1, 1, 1, 1, 32'h5000,     0, 1, 0, 32'h0,        0,   1, 32'h5000,     0, 1, 0));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        0, 1, 0, 32'h0,        0,   0, 32'h0,        0, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        0, 0, 1, 32'h55555000, 0,   0, 32'h0,        1, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0,   0, 32'h0,        0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0,   1, 32'h5004,     0, 0, 0));
        // Error response for 0x5004, then continue (or stop with the error-stop feature)
        vecs.push_back(v(1, 1, 0, 0, 32'h0,        1, 0, 1, 32'h55555004, 1,   0, 32'h0,        1, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        1, 0, 0, 32'h0,        0,   ~stop_en, 32'h5008, 0, 0, 0));
        // Mid-operation reset: state seen before the edge, cleared after it
        vecs.push_back(v(1, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0,   ~stop_en, 32'h5008, 0, 0, ~stop_en));
        vecs.push_back(v(1, 1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Held request granted in the same cycle as a response and a branch
        apply(v(1, 1, 1, 1, 32'h7000, 1, 1, 0, 32'h0,        0, 1, 32'h7000, 0, 1, 0), "hs0");
        apply(v(1, 1, 1, 0, 32'h0,    1, 0, 0, 32'h0,        0, 1, 32'h7004, 0, 0, 1), "hs1");
        apply(v(1, 1, 1, 1, 32'h8002, 1, 1, 1, 32'h77777000, 0, 1, 32'h7004, 0, 1, 1), "hs2");
        apply(v(1, 1, 1, 0, 32'h0,    1, 1, 0, 32'h0,        0, 1, 32'h8000, 0, 0, 1), "hs3");
        apply(v(1, 1, 0, 0, 32'h0,    1, 0, 1, 32'h77777004, 0, 0, 32'h0,    0, 0, 1), "hs4");
        apply(v(1, 1, 0, 0, 32'h0,    1, 0, 1, 32'h88888000, 0, 0, 32'h0,    1, 0, 1), "hs5");
        apply(v(1, 1, 0, 0, 32'h0,    1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0), "hs6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
